std_piso_shift: RTL

//  Parallel-in serial-out transmitter: accepts a DW-bit word over a valid/ready handshake.

---
 rtl/std_piso_shift_if.sv | 24 ++
 rtl/std_piso_shift.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/std_piso_shift_if.sv
// Word-in / bit-out bundle for the parallel-in serial-out transmitter.
// The producer (master) drives the word and bit tick; the transmitter (slave) drives the line.
interface std_piso_shift_if #(
    parameter int DW = 8
);
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          bit_en;
    logic          sout;
    logic          sout_valid;
    logic          last;
    logic          busy;

    modport master (
        output din, din_valid, bit_en,
        input  din_ready, sout, sout_valid, last, busy
    );

    modport slave (
        input  din, din_valid, bit_en,
        output din_ready, sout, sout_valid, last, busy
    );
endinterface

// File: rtl/std_piso_shift.sv
// Parallel-in serial-out transmitter: takes a DW-bit word on valid/ready and
// shifts it out one bit per bit_en tick on a registered line, back-to-back capable.
module std_piso_shift #(
    parameter int DW         = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit INV_OUT    = 1'b0,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    std_piso_shift_if.slave bus
);

    localparam int            CW       = $clog2(DW);
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_r, state_n_s;
    logic [CW-1:0]   cnt_r, cnt_n_s, cnt_inc_s;
    logic [DW-1:0]   shreg_r, shreg_n_s;
    logic            sout_r, sout_n_s;
    logic            sout_valid_r, sout_valid_n_s;
    logic            last_r, last_n_s;
    logic            din_ready_s;

    // Bit that goes on the line next, taken from the head of a word.
    function automatic logic head_bit(input logic [DW-1:0] word);
        if (LSB_FIRST) begin
            head_bit = word[0];
        end else begin
            head_bit = word[DW-1];
        end
    endfunction

    // Word with its head bit consumed, so the following bit becomes the head.
    function automatic logic [DW-1:0] advance_word(input logic [DW-1:0] word);
        if (LSB_FIRST) begin
            advance_word = {1'b0, word[DW-1:1]};
        end else begin
            advance_word = {word[DW-2:0], 1'b0};
        end
    endfunction

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_n_s      = state_r;
        cnt_n_s        = cnt_r;
        shreg_n_s      = shreg_r;
        sout_n_s       = sout_r;
        sout_valid_n_s = sout_valid_r;
        last_n_s       = last_r;
        din_ready_s    = 1'b0;
        cnt_inc_s      = cnt_r + CW'(1);
        case (state_r)
            IDLE: begin
                din_ready_s = 1'b1;
                if (bus.din_valid) begin
                    state_n_s      = SHIFT;
                    cnt_n_s        = {CW{1'b0}};
                    shreg_n_s      = advance_word(bus.din);
                    sout_n_s       = head_bit(bus.din) ^ INV_OUT;
                    sout_valid_n_s = 1'b1;
                    last_n_s       = 1'b0;
                end else begin
                    sout_n_s       = IDLE_LEVEL;
                    sout_valid_n_s = 1'b0;
                    last_n_s       = 1'b0;
                end
            end
            SHIFT: begin
                din_ready_s = last_r & bus.bit_en;
                if (bus.bit_en) begin
                    if (last_r) begin
                        // A waiting word follows the last bit with no idle gap.
                        if (bus.din_valid) begin
                            state_n_s      = SHIFT;
                            cnt_n_s        = {CW{1'b0}};
                            shreg_n_s      = advance_word(bus.din);
                            sout_n_s       = head_bit(bus.din) ^ INV_OUT;
                            sout_valid_n_s = 1'b1;
                            last_n_s       = 1'b0;
                        end else begin
                            state_n_s      = IDLE;
                            cnt_n_s        = {CW{1'b0}};
                            shreg_n_s      = {DW{1'b0}};
                            sout_n_s       = IDLE_LEVEL;
                            sout_valid_n_s = 1'b0;
                            last_n_s       = 1'b0;
                        end
                    end else begin
                        cnt_n_s   = cnt_inc_s;
                        shreg_n_s = advance_word(shreg_r);
                        sout_n_s  = head_bit(shreg_r) ^ INV_OUT;
                        last_n_s  = (cnt_inc_s == LAST_CNT);
                    end
                end else begin
                    state_n_s = SHIFT;
                end
            end
            default: begin
                state_n_s      = IDLE;
                cnt_n_s        = {CW{1'b0}};
                shreg_n_s      = {DW{1'b0}};
                sout_n_s       = IDLE_LEVEL;
                sout_valid_n_s = 1'b0;
                last_n_s       = 1'b0;
            end
        endcase
    end

    // State, counter, shift register and registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            shreg_r      <= {DW{1'b0}};
            sout_r       <= IDLE_LEVEL;
            sout_valid_r <= 1'b0;
            last_r       <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            cnt_r        <= cnt_n_s;
            shreg_r      <= shreg_n_s;
            sout_r       <= sout_n_s;
            sout_valid_r <= sout_valid_n_s;
            last_r       <= last_n_s;
        end
    end

    assign bus.din_ready  = din_ready_s;
    assign bus.sout       = sout_r;
    assign bus.sout_valid = sout_valid_r;
    assign bus.last       = last_r;
    assign bus.busy       = (state_r == SHIFT);

endmodule
